operand_entry: RTL and testbench



---
 rtl/operand_entry_if.sv | 16 +
 rtl/operand_entry.sv | 109 ++++++++++
 tb/tb_operand_entry.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_if.sv
// Operand-entry bus: raw switch/button inputs in, registered operands and status out.
interface operand_entry_if;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       op;
  logic       valid;
  logic [1:0] led_state;

  modport master (output sw, btn_load, btn_op,
                  input  in_a, in_b, op, valid, led_state);
  modport slave  (input  sw, btn_load, btn_op,
                  output in_a, in_b, op, valid, led_state);
endinterface

// File: rtl/operand_entry.sv
// Button sync/debounce plus A-then-B operand capture FSM feeding the 4-bit add/sub datapath.
// Every output comes straight from a flop so the downstream adder never sees glitches.

module operand_entry_deb #(
  parameter int                  DEB_SIZE  = 16,
  parameter logic [DEB_SIZE-1:0] DEB_LIMIT = 16'd60000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw,
  output logic press
);
  localparam logic [DEB_SIZE-1:0] LIM_M1 = DEB_LIMIT - DEB_SIZE'(1);

  logic [1:0]          sync;
  logic                db, db_d;
  logic [DEB_SIZE-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync  <= '0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      db_d  <= db;
      press <= db & ~db_d;
      // counter only survives while the synced input keeps disagreeing with db
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == LIM_M1) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + DEB_SIZE'(1);
      end
    end
  end
endmodule

module operand_entry #(
  parameter int                  DEB_SIZE  = 16,
  parameter logic [DEB_SIZE-1:0] DEB_LIMIT = 16'd60000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  operand_entry_if.slave  bus
);
  localparam int NUM_BTN = 2;
  localparam logic [1:0] GET_A = 2'b00;
  localparam logic [1:0] GET_B = 2'b01;
  localparam logic [1:0] SHOW  = 2'b10;

  logic [NUM_BTN-1:0] raw, press;
  logic               load_p, op_p;
  logic [1:0]         state;
  logic [3:0]         a_q, b_q;
  logic               op_q, valid_q;

  assign raw    = {bus.btn_op, bus.btn_load};
  assign load_p = press[0];
  assign op_p   = press[1];

  operand_entry_deb #(.DEB_SIZE(DEB_SIZE), .DEB_LIMIT(DEB_LIMIT)) u_deb [NUM_BTN-1:0] (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .raw    (raw),
    .press  (press)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (op_p) op_q <= ~op_q;
      case (state)
        GET_A: if (load_p) begin
          a_q   <= bus.sw;
          state <= GET_B;
        end
        GET_B: if (load_p) begin
          b_q     <= bus.sw;
          valid_q <= 1'b1;
          state   <= SHOW;
        end
        SHOW: if (load_p) begin
          valid_q <= 1'b0;
          state   <= GET_A;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= GET_A;
        end
      endcase
    end
  end

  assign bus.in_a      = a_q;
  assign bus.in_b      = b_q;
  assign bus.op        = op_q;
  assign bus.valid     = valid_q;
  assign bus.led_state = state;
endmodule

// File: tb/tb_operand_entry.sv
// Directed + randomized bench for operand_entry with a short debounce window.
module tb_operand_entry;
  localparam int LIM = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  operand_entry_if bus();

  operand_entry #(.DEB_SIZE(16), .DEB_LIMIT(16'd4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: button stream delayed two samples, then "LIM consecutive
  // disagreeing samples flips the stable level"; each rise schedules its action
  // two edges later.
  int m_q0 [2], m_q1 [2], m_db [2], m_run [2];
  int due_load [$];
  int due_op   [$];
  int m_a, m_b, m_op, m_valid, m_phase;
  int edge_n = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q0[i] = 0; m_q1[i] = 0; m_db[i] = 0; m_run[i] = 0;
    end
    due_load.delete();
    due_op.delete();
    m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_phase = 0;
  endtask

  task automatic model_edge();
    bit ld, tg;
    int raw, synced;
    ld = 0; tg = 0;
    if (rst_in) return;
    edge_n++;
    while (due_load.size() > 0 && due_load[0] == edge_n) begin void'(due_load.pop_front()); ld = 1; end
    while (due_op.size() > 0 && due_op[0] == edge_n) begin void'(due_op.pop_front()); tg = 1; end
    if (tg) m_op = 1 - m_op;
    if (ld) begin
      case (m_phase)
        0: begin m_a = int'(bus.sw); m_phase = 1; end
        1: begin m_b = int'(bus.sw); m_valid = 1; m_phase = 2; end
        default: begin m_valid = 0; m_phase = 0; end
      endcase
    end
    for (int b = 0; b < 2; b++) begin
      raw    = (b == 0) ? int'(bus.btn_load) : int'(bus.btn_op);
      synced = m_q1[b];
      m_q1[b] = m_q0[b];
      m_q0[b] = raw;
      if (synced != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == LIM) begin
          m_db[b] = synced;
          m_run[b] = 0;
          if (synced == 1) begin
            if (b == 0) due_load.push_back(edge_n + 2);
            else        due_op.push_back(edge_n + 2);
          end
        end
      end else begin
        m_run[b] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("in_a",      32'(bus.in_a),      32'(m_a));
    chk("in_b",      32'(bus.in_b),      32'(m_b));
    chk("op",        32'(bus.op),        32'(m_op));
    chk("valid",     32'(bus.valid),     32'(m_valid));
    chk("led_state", 32'(bus.led_state), 32'(m_phase));
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_all();
  endtask

  task automatic press(input bit ld, input bit opb, input logic [3:0] s);
    bus.sw = s; bus.btn_load = ld; bus.btn_op = opb;
    repeat (10) tick();
    bus.btn_load = 1'b0; bus.btn_op = 1'b0;
    repeat (10) tick();
  endtask

  logic [3:0] s;
  logic [3:0] sa, sb;
  logic       pat [6];

  initial begin
    bus.sw = 4'd0; bus.btn_load = 1'b0; bus.btn_op = 1'b0;
    rst_in = 1'b1;
    model_reset();
    #1 check_all();
    chk("rst_a_const", 32'(bus.in_a), 32'd0);
    repeat (2) tick();
    rst_in = 1'b0;
    repeat (20) tick();

    // operand A: exact latency from the raw edge
    bus.sw = 4'd9; bus.btn_load = 1'b1;
    repeat (7) tick();
    chk("a_before_latency", 32'(bus.in_a), 32'd0);
    tick();
    chk("a_at_latency", 32'(bus.in_a), 32'd9);
    chk("led_get_b", 32'(bus.led_state), 32'd1);
    repeat (2) tick();
    bus.btn_load = 1'b0;
    repeat (10) tick();

    press(1, 0, 4'd5);
    chk("b_captured", 32'(bus.in_b), 32'd5);
    chk("valid_show", 32'(bus.valid), 32'd1);
    chk("led_show",   32'(bus.led_state), 32'd2);

    // bounce then steady: a single SHOW -> GET_A step
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (pat[i]) begin bus.btn_load = pat[i]; tick(); end
    bus.btn_load = 1'b1;
    repeat (12) tick();
    bus.btn_load = 1'b0;
    repeat (10) tick();
    chk("bounce_one_step", 32'(bus.led_state), 32'd0);
    chk("bounce_a_kept",   32'(bus.in_a), 32'd9);

    // too-short pulse is ignored
    bus.btn_load = 1'b1;
    repeat (3) tick();
    bus.btn_load = 1'b0;
    repeat (10) tick();
    chk("short_ignored", 32'(bus.led_state), 32'd0);

    sa = 4'($urandom); sb = 4'($urandom);
    press(1, 0, sa);
    press(1, 0, sb);
    chk("show_again", 32'(bus.led_state), 32'd2);
    press(0, 1, 4'($urandom));
    chk("op_toggle1", 32'(bus.op), 32'd1);
    chk("op_state",   32'(bus.led_state), 32'd2);
    chk("op_a_kept",  32'(bus.in_a), 32'(sa));
    chk("op_b_kept",  32'(bus.in_b), 32'(sb));
    press(0, 1, 4'($urandom));
    chk("op_toggle2", 32'(bus.op), 32'd0);

    // simultaneous load + op in GET_B
    press(1, 0, 4'($urandom));
    press(1, 0, 4'($urandom));
    s = 4'($urandom);
    press(1, 1, s);
    chk("sim_b",     32'(bus.in_b), 32'(s));
    chk("sim_valid", 32'(bus.valid), 32'd1);
    chk("sim_op",    32'(bus.op), 32'd1);

    // reset mid-debounce in GET_B, button kept held through release
    press(1, 0, 4'($urandom));
    press(1, 0, 4'($urandom));
    chk("pre_rst_get_b", 32'(bus.led_state), 32'd1);
    s = 4'($urandom);
    bus.sw = s; bus.btn_load = 1'b1;
    repeat (2) tick();
    #2 rst_in = 1'b1;
    model_reset();
    #1 check_all();
    chk("rst_op_const", 32'(bus.op), 32'd0);
    tick();
    rst_in = 1'b0;
    repeat (7) tick();
    chk("post_rst_wait", 32'(bus.in_a), 32'd0);
    tick();
    chk("post_rst_a",   32'(bus.in_a), 32'(s));
    chk("post_rst_led", 32'(bus.led_state), 32'd1);
    bus.btn_load = 1'b0;
    repeat (10) tick();

    // random button activity with random hold lengths
    repeat (60) begin
      bus.btn_load = 1'($urandom_range(0, 1));
      bus.btn_op   = 1'($urandom_range(0, 1));
      bus.sw       = 4'($urandom);
      repeat ($urandom_range(1, 8)) tick();
    end
    bus.btn_load = 1'b0; bus.btn_op = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
